// File: rtl/rs_age_param.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_param
// Purpose  : Parametrised reservation station. Selects the oldest ready entry
//            per issue port from an age matrix, wakes sources from several
//            CDB tags, and supports a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module rs_age_param #(
    parameter int N_ENTRIES = 16,
    parameter int DISP_W    = 3,
    parameter int ISSUE_W   = 3,
    parameter int CDB_W     = 3,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64,
    parameter int FU_W      = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1,
    parameter int OCC_W     = $clog2(N_ENTRIES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DISP_W-1:0]             disp_valid,
    input  logic [DISP_W*FU_W-1:0]        disp_fu,
    input  logic [DISP_W*PREG_W-1:0]      disp_src1_pr,
    input  logic [DISP_W*PREG_W-1:0]      disp_src2_pr,
    input  logic [DISP_W-1:0]             disp_src1_rdy,
    input  logic [DISP_W-1:0]             disp_src2_rdy,
    input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
    output logic [DISP_W-1:0]             disp_stall,
    input  logic [CDB_W-1:0]              cdb_valid,
    input  logic [CDB_W*PREG_W-1:0]       cdb_tag,
    input  logic [ISSUE_W-1:0]            fu_stall,
    output logic [ISSUE_W-1:0]            issue_valid,
    output logic [ISSUE_W*PREG_W-1:0]     issue_src1_pr,
    output logic [ISSUE_W*PREG_W-1:0]     issue_src2_pr,
    output logic [ISSUE_W*PAYLOAD_W-1:0]  issue_payload,
    output logic [OCC_W-1:0]              occupancy
);

    localparam int SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;
    localparam logic [N_ENTRIES-1:0] c_ENTRY_LSB = {{(N_ENTRIES-1){1'b0}}, 1'b1};

    // Entry storage; r_older[i][j] = 1 means entry i is older than entry j
    logic [N_ENTRIES-1:0]                 r_valid;
    logic [N_ENTRIES-1:0]                 r_rdy1;
    logic [N_ENTRIES-1:0]                 r_rdy2;
    logic [N_ENTRIES-1:0][FU_W-1:0]       r_fu;
    logic [N_ENTRIES-1:0][PREG_W-1:0]     r_src1;
    logic [N_ENTRIES-1:0][PREG_W-1:0]     r_src2;
    logic [N_ENTRIES-1:0][PAYLOAD_W-1:0]  r_payload;
    logic [N_ENTRIES-1:0][N_ENTRIES-1:0]  r_older;
    logic [OCC_W-1:0]                     r_occ;

    logic [ISSUE_W-1:0]                   r_iss_valid;
    logic [ISSUE_W-1:0][PREG_W-1:0]       r_iss_src1;
    logic [ISSUE_W-1:0][PREG_W-1:0]       r_iss_src2;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    r_iss_payload;

    logic [N_ENTRIES-1:0]                 w_wake1;
    logic [N_ENTRIES-1:0]                 w_wake2;
    logic [DISP_W-1:0]                    w_byp1;
    logic [DISP_W-1:0]                    w_byp2;
    logic [DISP_W-1:0]                    w_accept;
    logic [N_ENTRIES-1:0]                 w_free;
    logic                                 w_found;
    logic [N_ENTRIES-1:0]                 w_new;
    logic [N_ENTRIES-1:0][SLOT_W-1:0]     w_new_slot;
    logic [ISSUE_W-1:0][N_ENTRIES-1:0]    w_elig;
    logic [ISSUE_W-1:0][N_ENTRIES-1:0]    w_sel;
    logic [ISSUE_W-1:0]                   w_sel_any;
    logic [N_ENTRIES-1:0]                 w_issued;
    logic [N_ENTRIES-1:0]                 w_stay;
    logic [ISSUE_W-1:0][PREG_W-1:0]       w_iss_src1;
    logic [ISSUE_W-1:0][PREG_W-1:0]       w_iss_src2;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    w_iss_payload;
    logic [N_ENTRIES-1:0][N_ENTRIES-1:0]  w_older_nxt;
    logic [OCC_W-1:0]                     w_occ_nxt;

    function automatic logic f_cdb_hit(input logic [PREG_W-1:0]       tag,
                                       input logic [CDB_W-1:0]        vld,
                                       input logic [CDB_W*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && (tags[c*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [OCC_W-1:0] f_popcount(input logic [N_ENTRIES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int e = 0; e < N_ENTRIES; e++) cnt = cnt + OCC_W'(v[e]);
        return cnt;
    endfunction

    // Room is judged on registered occupancy only
    for (genvar i = 0; i < DISP_W; i++) begin : g_stall
        assign disp_stall[i] = ({1'b0, r_occ} + (OCC_W+1)'(i + 1)) > (OCC_W+1)'(N_ENTRIES);
    end

    assign w_accept = disp_valid & ~disp_stall & {DISP_W{~flush}};

    always_comb begin
        for (int e = 0; e < N_ENTRIES; e++) begin
            w_wake1[e] = f_cdb_hit(r_src1[e], cdb_valid, cdb_tag);
            w_wake2[e] = f_cdb_hit(r_src2[e], cdb_valid, cdb_tag);
        end
        for (int i = 0; i < DISP_W; i++) begin
            w_byp1[i] = disp_src1_rdy[i] | f_cdb_hit(disp_src1_pr[i*PREG_W +: PREG_W], cdb_valid, cdb_tag);
            w_byp2[i] = disp_src2_rdy[i] | f_cdb_hit(disp_src2_pr[i*PREG_W +: PREG_W], cdb_valid, cdb_tag);
        end
    end

    // Accepted slots take the lowest free entries in slot order
    always_comb begin
        w_free     = ~r_valid;
        w_new      = '0;
        w_new_slot = '0;
        w_found    = 1'b0;
        for (int i = 0; i < DISP_W; i++) begin
            w_found = 1'b0;
            if (w_accept[i]) begin
                for (int e = 0; e < N_ENTRIES; e++) begin
                    if (!w_found && w_free[e]) begin
                        w_found       = 1'b1;
                        w_free[e]     = 1'b0;
                        w_new[e]      = 1'b1;
                        w_new_slot[e] = SLOT_W'(i);
                    end
                end
            end
        end
    end

    // Winner on a port is the eligible entry older than every other eligible one
    always_comb begin
        w_elig    = '0;
        w_sel     = '0;
        w_sel_any = '0;
        w_issued  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                w_elig[k][e] = r_valid[e] & r_rdy1[e] & r_rdy2[e] &
                               (r_fu[e] == FU_W'(k)) & ~fu_stall[k];
            end
            for (int e = 0; e < N_ENTRIES; e++) begin
                w_sel[k][e] = w_elig[k][e] &&
                              ((w_elig[k] & ~r_older[e] & ~(c_ENTRY_LSB << e)) == '0);
            end
            w_sel_any[k] = |w_sel[k];
            w_issued     = w_issued | w_sel[k];
        end
    end

    always_comb begin
        w_iss_src1    = '0;
        w_iss_src2    = '0;
        w_iss_payload = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                if (w_sel[k][e]) begin
                    w_iss_src1[k]    = w_iss_src1[k] | r_src1[e];
                    w_iss_src2[k]    = w_iss_src2[k] | r_src2[e];
                    w_iss_payload[k] = w_iss_payload[k] | r_payload[e];
                end
            end
        end
    end

    // New entries are younger than survivors; lower slot is older within a group
    always_comb begin
        w_stay      = r_valid & ~w_issued;
        w_older_nxt = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (w_new[i] && w_new[j])
                    w_older_nxt[i][j] = (w_new_slot[i] < w_new_slot[j]);
                else if (w_new[j])
                    w_older_nxt[i][j] = w_stay[i];
                else if (w_new[i])
                    w_older_nxt[i][j] = 1'b0;
                else
                    w_older_nxt[i][j] = r_older[i][j] & w_stay[i] & w_stay[j];
            end
        end
    end

    assign w_occ_nxt = r_occ + f_popcount(N_ENTRIES'(w_accept)) - f_popcount(w_issued);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= '0;
            r_rdy1        <= '0;
            r_rdy2        <= '0;
            r_fu          <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_payload     <= '0;
            r_older       <= '0;
            r_occ         <= '0;
            r_iss_valid   <= '0;
            r_iss_src1    <= '0;
            r_iss_src2    <= '0;
            r_iss_payload <= '0;
        end else if (flush) begin
            r_valid     <= '0;
            r_older     <= '0;
            r_occ       <= '0;
            r_iss_valid <= '0;
        end else begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                if (w_new[e]) begin
                    r_valid[e]   <= 1'b1;
                    r_fu[e]      <= disp_fu[w_new_slot[e]*FU_W +: FU_W];
                    r_src1[e]    <= disp_src1_pr[w_new_slot[e]*PREG_W +: PREG_W];
                    r_src2[e]    <= disp_src2_pr[w_new_slot[e]*PREG_W +: PREG_W];
                    r_payload[e] <= disp_payload[w_new_slot[e]*PAYLOAD_W +: PAYLOAD_W];
                    r_rdy1[e]    <= w_byp1[w_new_slot[e]];
                    r_rdy2[e]    <= w_byp2[w_new_slot[e]];
                end else begin
                    if (w_issued[e]) r_valid[e] <= 1'b0;
                    r_rdy1[e] <= r_rdy1[e] | w_wake1[e];
                    r_rdy2[e] <= r_rdy2[e] | w_wake2[e];
                end
            end
            r_older     <= w_older_nxt;
            r_occ       <= w_occ_nxt;
            r_iss_valid <= w_sel_any;
            for (int k = 0; k < ISSUE_W; k++) begin
                if (w_sel_any[k]) begin
                    r_iss_src1[k]    <= w_iss_src1[k];
                    r_iss_src2[k]    <= w_iss_src2[k];
                    r_iss_payload[k] <= w_iss_payload[k];
                end
            end
        end
    end

    assign occupancy     = r_occ;
    assign issue_valid   = r_iss_valid;
    assign issue_src1_pr = r_iss_src1;
    assign issue_src2_pr = r_iss_src2;
    assign issue_payload = r_iss_payload;

endmodule
`default_nettype wire

// File: tb/tb_rs_age_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_age_param
// Purpose  : Self-checking bench for rs_age_param against an age-ordered queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_age_param;
    localparam int N  = 16;
    localparam int DW = 3;
    localparam int IW = 3;
    localparam int CW = 3;
    localparam int PW = 6;
    localparam int LW = 64;
    localparam int FW = 2;
    localparam int OW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic [DW-1:0]    disp_valid = '0;
    logic [DW*FW-1:0] disp_fu = '0;
    logic [DW*PW-1:0] disp_src1_pr = '0;
    logic [DW*PW-1:0] disp_src2_pr = '0;
    logic [DW-1:0]    disp_src1_rdy = '0;
    logic [DW-1:0]    disp_src2_rdy = '0;
    logic [DW*LW-1:0] disp_payload = '0;
    logic [DW-1:0]    disp_stall;
    logic [CW-1:0]    cdb_valid = '0;
    logic [CW*PW-1:0] cdb_tag = '0;
    logic [IW-1:0]    fu_stall = '0;
    logic [IW-1:0]    issue_valid;
    logic [IW*PW-1:0] issue_src1_pr;
    logic [IW*PW-1:0] issue_src2_pr;
    logic [IW*LW-1:0] issue_payload;
    logic [OW-1:0]    occupancy;

    rs_age_param #(.N_ENTRIES(N), .DISP_W(DW), .ISSUE_W(IW), .CDB_W(CW),
                   .PREG_W(PW), .PAYLOAD_W(LW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_fu(disp_fu),
        .disp_src1_pr(disp_src1_pr), .disp_src2_pr(disp_src2_pr),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_payload(disp_payload), .disp_stall(disp_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_stall(fu_stall),
        .issue_valid(issue_valid), .issue_src1_pr(issue_src1_pr),
        .issue_src2_pr(issue_src2_pr), .issue_payload(issue_payload),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DW; i++)
                assert (!(disp_valid[i] && (disp_fu[i*FW +: FW] >= FW'(IW))))
                    else $error("illegal disp_fu on slot %0d", i);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue in age order, front is oldest
    typedef struct {
        int             fu;
        logic [PW-1:0]  s1;
        logic [PW-1:0]  s2;
        bit             r1;
        bit             r2;
        logic [LW-1:0]  pl;
    } ent_t;

    ent_t          q[$];
    logic [IW-1:0] e_iv;
    logic [PW-1:0] e_s1 [IW];
    logic [PW-1:0] e_s2 [IW];
    logic [LW-1:0] e_pl [IW];

    function automatic bit hit(input logic [PW-1:0] t);
        for (int c = 0; c < CW; c++)
            if (cdb_valid[c] && cdb_tag[c*PW +: PW] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        e_iv = '0;
        for (int k = 0; k < IW; k++) begin
            e_s1[k] = '0; e_s2[k] = '0; e_pl[k] = '0;
        end
    endtask

    task automatic model_edge();
        ent_t nq[$];
        ent_t t;
        int   pick [IW];
        int   sz;
        bit   taken;
        if (flush) begin
            q.delete();
            e_iv = '0;
            return;
        end
        sz = q.size();
        for (int k = 0; k < IW; k++) begin
            pick[k] = -1;
            for (int x = 0; x < sz; x++)
                if (pick[k] < 0 && q[x].fu == k && q[x].r1 && q[x].r2 && !fu_stall[k]) pick[k] = x;
            e_iv[k] = (pick[k] >= 0);
            if (pick[k] >= 0) begin
                e_s1[k] = q[pick[k]].s1;
                e_s2[k] = q[pick[k]].s2;
                e_pl[k] = q[pick[k]].pl;
            end
        end
        for (int x = 0; x < sz; x++) begin
            taken = 1'b0;
            for (int k = 0; k < IW; k++) if (pick[k] == x) taken = 1'b1;
            if (!taken) begin
                t = q[x];
                t.r1 = t.r1 | hit(t.s1);
                t.r2 = t.r2 | hit(t.s2);
                nq.push_back(t);
            end
        end
        for (int i = 0; i < DW; i++) begin
            if (disp_valid[i] && (sz + i + 1 <= N)) begin
                t.fu = int'(disp_fu[i*FW +: FW]);
                t.s1 = disp_src1_pr[i*PW +: PW];
                t.s2 = disp_src2_pr[i*PW +: PW];
                t.r1 = disp_src1_rdy[i] | hit(t.s1);
                t.r2 = disp_src2_rdy[i] | hit(t.s2);
                t.pl = disp_payload[i*LW +: LW];
                nq.push_back(t);
            end
        end
        q = nq;
    endtask

    task automatic check_model();
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        for (int i = 0; i < DW; i++)
            chk($sformatf("disp_stall[%0d]", i), 64'(disp_stall[i]), 64'((N - q.size()) < i + 1));
        chk("issue_valid", 64'(issue_valid), 64'(e_iv));
        for (int k = 0; k < IW; k++) begin
            if (e_iv[k]) begin
                chk($sformatf("issue_src1[%0d]", k), 64'(issue_src1_pr[k*PW +: PW]), 64'(e_s1[k]));
                chk($sformatf("issue_src2[%0d]", k), 64'(issue_src2_pr[k*PW +: PW]), 64'(e_s2[k]));
                chk($sformatf("issue_payload[%0d]", k), issue_payload[k*LW +: LW], e_pl[k]);
            end
        end
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = '0; disp_src1_rdy = '0; disp_src2_rdy = '0; cdb_valid = '0;
    endtask

    task automatic set_slot(input int i, input int fu, input int s1, input int s2,
                            input bit r1, input bit r2, input logic [LW-1:0] pl);
        disp_valid[i]             = 1'b1;
        disp_fu[i*FW +: FW]       = FW'(fu);
        disp_src1_pr[i*PW +: PW]  = PW'(s1);
        disp_src2_pr[i*PW +: PW]  = PW'(s2);
        disp_src1_rdy[i]          = r1;
        disp_src2_rdy[i]          = r2;
        disp_payload[i*LW +: LW]  = pl;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit dv; int fu; int s1; int s2; bit r1; bit r2;
        bit cv; int ctag;
        logic [IW-1:0] x_iv; int x_occ; int port; int x_s1; int x_s2;
    } vec_t;

    vec_t          tbl [11];
    logic [LW-1:0] pl_abc [3];

    initial begin
        tbl[0]  = '{1, 0, 1, 2, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, 2};
        tbl[2]  = '{1, 0, 3, 4, 0, 1, 1, 3, 3'b000, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 3, 4};
        tbl[4]  = '{1, 0, 3, 4, 0, 1, 1, 5, 3'b000, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 3, 3'b000, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 3, 4};
        tbl[9]  = '{1, 2, 7, 8, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 2, 7, 8};
        pl_abc[0] = 64'hAAAA_0000_0000_000A;
        pl_abc[1] = 64'hBBBB_0000_0000_000B;
        pl_abc[2] = 64'hCCCC_0000_0000_000C;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk("reset issue_valid", 64'(issue_valid), 64'd0);
        chk("reset disp_stall", 64'(disp_stall), 64'd0);
        chk("reset issue_src1", 64'(issue_src1_pr), 64'd0);
        rst = 1'b1;

        // Single-slot dispatch, bypass and late wakeup
        for (int r = 0; r < 11; r++) begin
            idle();
            fu_stall = '0;
            if (tbl[r].dv) set_slot(0, tbl[r].fu, tbl[r].s1, tbl[r].s2, tbl[r].r1, tbl[r].r2, 64'(r + 256));
            if (tbl[r].cv) begin
                cdb_valid[0]    = 1'b1;
                cdb_tag[PW-1:0] = PW'(tbl[r].ctag);
            end
            step();
            chk($sformatf("tbl%0d issue_valid", r), 64'(issue_valid), 64'(tbl[r].x_iv));
            chk($sformatf("tbl%0d occupancy", r), 64'(occupancy), 64'(tbl[r].x_occ));
            if (tbl[r].x_iv != '0) begin
                chk($sformatf("tbl%0d src1", r), 64'(issue_src1_pr[tbl[r].port*PW +: PW]), 64'(tbl[r].x_s1));
                chk($sformatf("tbl%0d src2", r), 64'(issue_src2_pr[tbl[r].port*PW +: PW]), 64'(tbl[r].x_s2));
            end
        end

        // Port 1 held off, then drains oldest first
        fu_stall = 3'b010;
        for (int c = 0; c < 3; c++) begin
            idle();
            set_slot(0, 1, 10 + c, 20 + c, 1, 1, pl_abc[c]);
            step();
            chk("stall hold iv1", 64'(issue_valid[1]), 64'd0);
        end
        idle();
        fu_stall = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("drain iv1", 64'(issue_valid[1]), 64'd1);
            chk("drain payload", issue_payload[LW +: LW], pl_abc[c]);
        end
        step();
        chk("drain done iv", 64'(issue_valid), 64'd0);

        // Fill to capacity
        fu_stall = 3'b111;
        for (int c = 0; c < 5; c++) begin
            idle();
            for (int i = 0; i < DW; i++) set_slot(i, i, c * 3 + i, 0, 1, 1, 64'(c * 3 + i));
            step();
        end
        chk("fill occupancy 15", 64'(occupancy), 64'd15);
        chk("fill disp_stall 110", 64'(disp_stall), 64'b110);
        for (int i = 0; i < DW; i++) set_slot(i, i, 40 + i, 0, 1, 1, 64'(40 + i));
        step();
        chk("full occupancy 16", 64'(occupancy), 64'd16);
        chk("full disp_stall 111", 64'(disp_stall), 64'b111);

        // Flush beats a simultaneous dispatch
        idle();
        flush = 1'b1;
        step();
        chk("flush clears", 64'(occupancy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            idle();
            for (int i = 0; i < ((c == 2) ? 2 : 3); i++) set_slot(i, i, 50 + i, 51, 1, 1, 64'(c));
            step();
        end
        chk("pre-flush occupancy 8", 64'(occupancy), 64'd8);
        for (int i = 0; i < DW; i++) set_slot(i, 0, 1, 2, 1, 1, 64'(99));
        flush = 1'b1;
        step();
        chk("flush occupancy", 64'(occupancy), 64'd0);
        chk("flush issue_valid", 64'(issue_valid), 64'd0);
        idle();
        fu_stall = '0;
        step();
        chk("flush drop occupancy", 64'(occupancy), 64'd0);
        chk("flush drop issue_valid", 64'(issue_valid), 64'd0);

        // Asynchronous reset mid-cycle with live entries
        fu_stall = 3'b111;
        for (int c = 0; c < 2; c++) begin
            idle();
            for (int i = 0; i < DW; i++) set_slot(i, i, 60 + i, 61, 1, 1, 64'(c));
            step();
        end
        idle();
        fu_stall = 3'b110;
        step();
        chk("pre-reset issue_valid", 64'(issue_valid), 64'b001);
        chk("pre-reset occupancy", 64'(occupancy), 64'd5);
        rst = 1'b0;
        model_reset();
        #1;
        chk("async reset occupancy", 64'(occupancy), 64'd0);
        chk("async reset issue_valid", 64'(issue_valid), 64'd0);
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b1;
        fu_stall = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post-reset occupancy", 64'(occupancy), 64'd0);
            chk("post-reset issue_valid", 64'(issue_valid), 64'd0);
        end

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle();
            flush = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < DW; i++)
                if ($urandom_range(0, 2) != 0)
                    set_slot(i, int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), {$urandom, $urandom});
            for (int k = 0; k < IW; k++) fu_stall[k] = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < CW; l++) begin
                cdb_valid[l]          = 1'($urandom_range(0, 1));
                cdb_tag[l*PW +: PW]   = PW'($urandom_range(0, 15));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rs_age_param.md
Name: rs_age_param

Overview:
Parametrised reservation station for the R10K out-of-order core. It sits between dispatch and the FU issue FIFOs, and generalises the 3-wide RS in dispatch width, issue width, entry count, CDB width and tag width. It adds two things the current RS lacks: true oldest-first selection per issue port through an age matrix, and a synchronous flush for branch mispredict recovery. Wakeup comes from multiple CDB tags per cycle, with same-cycle dispatch bypass.

Parameters:
N_ENTRIES, 16, number of RS entries (>= DISP_W)
DISP_W, 3, dispatch slots per cycle
ISSUE_W, 3, issue ports; port k serves FU class k
CDB_W, 3, CDB tags broadcast per cycle
PREG_W, 6, physical register tag width
PAYLOAD_W, 64, opaque instruction payload carried to the FU
FU_W, $clog2(ISSUE_W) (min 1), FU class field width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
flush  in  1  synchronous squash of all entries
disp_valid  in  DISP_W  per-slot dispatch request
disp_fu  in  DISP_W*FU_W  FU class per slot
disp_src1_pr / disp_src2_pr  in  DISP_W*PREG_W  source tags
disp_src1_rdy / disp_src2_rdy  in  DISP_W  source ready at dispatch
disp_payload  in  DISP_W*PAYLOAD_W  payload per slot
disp_stall  out  DISP_W  structural halt, thermometer-coded
cdb_valid  in  CDB_W  broadcast valid per lane
cdb_tag  in  CDB_W*PREG_W  broadcast tags
fu_stall  in  ISSUE_W  per-port back-pressure from FU FIFO
issue_valid  out  ISSUE_W  registered issue valid
issue_src1_pr / issue_src2_pr  out  ISSUE_W*PREG_W  issued source tags
issue_payload  out  ISSUE_W*PAYLOAD_W  issued payload
occupancy  out  $clog2(N_ENTRIES+1)  registered count of valid entries

Behaviour:
- Entry state: valid, fu, src1/src2 tag, rdy1/rdy2, payload, plus an N×N age matrix (older[i][j]=1 means entry i is older than entry j).
- Reset (rst=0, asynchronous): every valid bit = 0, age matrix = 0, issue_valid = 0, issue_* data = 0, occupancy = 0, disp_stall = 0. These values hold while rst=0. The first edge after release operates normally.
- disp_stall[i] = (N_ENTRIES - occupancy) < i+1. It is derived from registered occupancy only; entries freed by the same cycle's issue are not counted.
- Accept rule:
  - Slot i is accepted iff disp_valid[i] && !disp_stall[i] && !flush.
  - Accepted slots allocate the lowest-indexed free entries in slot order.
  - Slots need not be contiguous.
- Age on allocation:
  - A new entry is younger than every existing valid entry.
  - Among slots accepted in the same cycle, a lower slot index is older.
- Dispatch bypass: a dispatched source is written ready if disp_srcN_rdy=1, or if its tag equals any cdb_tag with cdb_valid set in the same cycle.
- Wakeup: on each edge, any valid entry whose srcN tag matches a valid cdb_tag sets rdyN. Multiple matches are harmless.
- Select (combinational on registered state):
  - Entry e is eligible for port k iff valid && rdy1 && rdy2 && fu==k && !fu_stall[k].
  - Port k picks the single eligible entry that is older than all other eligible entries for port k.
- Issue timing:
  - At the edge, selected entries are freed and their fields are registered onto issue_* with issue_valid[k]=1.
  - A port with no selection registers issue_valid[k]=0; its data is don't-care but stable.
- Latency:
  - Dispatch edge with both sources ready → issue_valid high after the next edge (1 cycle).
  - CDB wakeup edge → issue after the following edge.
- fu_stall[k]: no selection on port k. Entries remain resident and no issue is held or replayed.
- flush (synchronous, highest priority): at the edge, all valid bits = 0, occupancy = 0, issue_valid = 0. Same-cycle dispatch and CDB are ignored.
- occupancy_next = occupancy + accepted - issued. It never exceeds N_ENTRIES.
- A disp_fu value >= ISSUE_W is illegal; the bench asserts on it.
- Age matrix maintenance:
  - On allocation, set the new entry's row for every current valid entry to 0 and its column to 1.
  - Freeing an entry clears its row and column.
  - No counter wrap is possible.

Test Plan:
1. Hold rst=0 mid-run with 5 entries valid → occupancy=0, issue_valid=0 immediately (before the next clk edge); stays 0 for 3 cycles after rst=1 with no dispatch.
2. Dispatch slot0 fu=0, src1=1, src2=2, both rdy → next cycle issue_valid=3'b001, issue_src1_pr[0]=1, issue_src2_pr[0]=2; occupancy goes 1 → 0.
3. Dispatch src1=3 not ready, src2 ready, with cdb_tag[0]=3 valid in the same cycle → issues 1 cycle later. Repeat with cdb_tag=5 → no issue until tag 3 is broadcast, then issue 1 cycle after that broadcast.
4. fu_stall[1]=1; dispatch ready fu=1 entries with payloads A, B, C in 3 consecutive cycles; drop the stall → port 1 issues A, B, C on 3 consecutive cycles, and issue_valid[1]=0 while the stall is held.
5. N_ENTRIES=16, 3 dispatches per cycle, all fu_stall=1:
   - After 5 cycles occupancy=15 and disp_stall=3'b110.
   - The next cycle accepts only slot0 → occupancy=16, disp_stall=3'b111.
6. 8 valid entries; assert flush with a simultaneous 3-slot dispatch → next cycle occupancy=0, issue_valid=0, and the dispatch is dropped.
